// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Moore FSM driving FetchCycle control strobes, IR handoff to decode and branch PC loads
// Ports: Clk/Reset (sync, active-low); Start, Halt, Br_Take, Br_Addr, Dec_Ready in;
//        IR_Valid, PC_Ld, PC_Inc, IR_Ld, MEM_En (strobes active-low), MEM_RW, ADDR_Src, PC_Addr, Busy, Fetch_Count out.
// Optional: FETCH_WAIT_STATES_EN inserts WaitCycles memory wait states between FETCH and LATCH.
module fetch_sequencer #(
   parameter int AddrWidth  = 8,
   parameter int SelectSize = 2,
   parameter int CountWidth = 16,
   parameter int WaitCycles = 1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Halt,
   input  logic                  Br_Take,
   input  logic [AddrWidth-1:0]  Br_Addr,
   input  logic                  Dec_Ready,
   output logic                  IR_Valid,
   output logic                  PC_Ld,
   output logic                  PC_Inc,
   output logic                  IR_Ld,
   output logic                  MEM_En,
   output logic                  MEM_RW,
   output logic [SelectSize-1:0] ADDR_Src,
   output logic [AddrWidth-1:0]  PC_Addr,
   output logic                  Busy,
   output logic [CountWidth-1:0] Fetch_Count
);
`ifdef FETCH_WAIT_STATES_EN
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, LATCH, INCR, HANDOFF, BRANCH} state_t;
   logic [3:0] wait_cnt;
`else
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, INCR, HANDOFF, BRANCH} state_t;
`endif
   state_t state, nxt;
   logic   halt_pending;
   if (WaitCycles < 1 || WaitCycles > 15) begin : g_bad_wait
      $error("WaitCycles must be 1..15");
   end
   assign MEM_RW   = 1'b1;
   assign ADDR_Src = '0;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (Start && !Halt) ? FETCH : IDLE;
`ifdef FETCH_WAIT_STATES_EN
         FETCH:   nxt = WAIT;
         WAIT:    nxt = (wait_cnt == 4'd1) ? LATCH : WAIT;
`else
         FETCH:   nxt = LATCH;
`endif
         LATCH:   nxt = INCR;
         INCR:    nxt = HANDOFF;
         HANDOFF: nxt = !Dec_Ready ? HANDOFF : (Halt || halt_pending) ? IDLE : Br_Take ? BRANCH : FETCH;
         BRANCH:  nxt = FETCH;
         default: nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state        <= IDLE;
         PC_Ld        <= 1'b1;
         PC_Inc       <= 1'b1;
         IR_Ld        <= 1'b1;
         MEM_En       <= 1'b1;
         IR_Valid     <= 1'b0;
         Busy         <= 1'b0;
         PC_Addr      <= '0;
         Fetch_Count  <= '0;
         halt_pending <= 1'b0;
`ifdef FETCH_WAIT_STATES_EN
         wait_cnt     <= '0;
`endif
      end else begin
         state    <= nxt;
`ifdef FETCH_WAIT_STATES_EN
         MEM_En   <= !(nxt == FETCH || nxt == WAIT || nxt == LATCH);
         if (nxt == FETCH) wait_cnt <= 4'(WaitCycles);
         else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
`else
         MEM_En   <= !(nxt == FETCH || nxt == LATCH);
`endif
         IR_Ld    <= nxt != LATCH;
         PC_Inc   <= nxt != INCR;
         PC_Ld    <= nxt != BRANCH;
         IR_Valid <= nxt == HANDOFF;
         Busy     <= nxt != IDLE;
         if (state == HANDOFF && Dec_Ready) Fetch_Count <= Fetch_Count + 1'b1;
         if (nxt == BRANCH) PC_Addr <= Br_Addr;
         halt_pending <= (nxt == IDLE) ? 1'b0 : (Halt && state != IDLE && state != HANDOFF) ? 1'b1 : halt_pending;
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against a position-counter model
module tb_fetch_sequencer;
`ifdef FETCH_WAIT_STATES_EN
   localparam int W = 2;
`else
   localparam int W = 0;
`endif
   localparam int HO = W + 4;
   logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Halt = 1'b0, Br_Take = 1'b0, Dec_Ready = 1'b0;
   logic [7:0]  Br_Addr = '0;
   logic        IR_Valid, PC_Ld, PC_Inc, IR_Ld, MEM_En, MEM_RW, Busy;
   logic [1:0]  ADDR_Src;
   logic [7:0]  PC_Addr;
   logic [15:0] Fetch_Count;
   int          checks = 0, errors = 0;
   int          pos = 0;
   logic        pend = 1'b0;
   logic [7:0]  m_pc = '0;
   logic [15:0] m_cnt = '0;
   fetch_sequencer #(.AddrWidth(8), .SelectSize(2), .CountWidth(16), .WaitCycles(W == 0 ? 1 : W)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Br_Take(Br_Take), .Br_Addr(Br_Addr),
      .Dec_Ready(Dec_Ready), .IR_Valid(IR_Valid), .PC_Ld(PC_Ld), .PC_Inc(PC_Inc), .IR_Ld(IR_Ld),
      .MEM_En(MEM_En), .MEM_RW(MEM_RW), .ADDR_Src(ADDR_Src), .PC_Addr(PC_Addr), .Busy(Busy),
      .Fetch_Count(Fetch_Count)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // pos: 0 idle, 1 fetch, 2..W+1 wait, W+2 latch, W+3 incr, W+4 handoff, -1 branch
   task automatic model(input logic r, s, h, b, input logic [7:0] a, input logic d);
      if (!r) begin
         pos = 0; pend = 0; m_pc = 0; m_cnt = 0;
      end else if (pos == 0) begin
         if (s && !h) pos = 1;
      end else if (pos == HO) begin
         if (d) begin
            m_cnt = m_cnt + 16'd1;
            if (h || pend) begin pos = 0; pend = 0; end
            else if (b) begin pos = -1; m_pc = a; end
            else pos = 1;
         end
      end else begin
         if (h) pend = 1;
         pos = (pos == -1) ? 1 : pos + 1;
      end
   endtask
   task automatic check_all();
      logic mem, ir, inc, ld;
      mem = !(pos >= 1 && pos <= W + 2);
      ir  = !(pos == W + 2);
      inc = !(pos == W + 3);
      ld  = !(pos == -1);
      chk("strobes", {PC_Ld, PC_Inc, IR_Ld, MEM_En, MEM_RW}, {ld, inc, ir, mem, 1'b1});
      chk("valid_busy", {IR_Valid, Busy}, {pos == HO, pos != 0});
      chk("addr_src", ADDR_Src, 0);
      chk("pc_addr", PC_Addr, m_pc);
      chk("fetch_count", Fetch_Count, m_cnt);
      chk("ld_inc_excl", !PC_Ld && !PC_Inc, 0);
   endtask
   task automatic step(input logic r, s, h, b, input logic [7:0] a, input logic d);
      Reset = r; Start = s; Halt = h; Br_Take = b; Br_Addr = a; Dec_Ready = d;
      @(posedge Clk);
      model(r, s, h, b, a, d);
      @(negedge Clk);
      check_all();
   endtask
   task automatic to_handoff();
      int n = 0;
      while (pos != HO && n < 40) begin
         step(1, 0, 0, 0, 8'h00, 0);
         n++;
      end
      chk("reach_handoff", IR_Valid, 1);
   endtask
   initial begin
      @(negedge Clk);
      repeat (2) step(0, 0, 0, 0, 8'h00, 0);
      repeat (3) step(1, 0, 0, 0, 8'h00, 0);
      chk("t1_busy", Busy, 0);
      chk("t1_pc_addr", PC_Addr, 0);
      chk("t1_count", Fetch_Count, 0);
      step(1, 1, 0, 0, 8'h00, 1);
      chk("t2_fetch", MEM_En, 0);
      repeat (3 + W) step(1, 0, 0, 0, 8'h00, 1);
      chk("t2_first_valid", IR_Valid, 1);
      repeat (9 + 2 * W) step(1, 0, 0, 0, 8'h00, 1);
      chk("t2_count3", Fetch_Count, 3);
      to_handoff();
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 8'h00, 0);
         chk("t3_hold_valid", IR_Valid, 1);
         chk("t3_hold_strobes", {PC_Ld, PC_Inc, IR_Ld, MEM_En}, 4'hF);
         chk("t3_hold_count", Fetch_Count, 3);
      end
      step(1, 0, 0, 0, 8'h00, 1);
      chk("t3_refetch", MEM_En, 0);
      chk("t3_count", Fetch_Count, 4);
      to_handoff();
      step(1, 0, 0, 1, 8'hA0, 1);
      chk("t4_pc_ld", PC_Ld, 0);
      chk("t4_pc_addr", PC_Addr, 8'hA0);
      step(1, 0, 0, 0, 8'h00, 1);
      chk("t4_fetch", {PC_Ld, MEM_En}, 2'b10);
      to_handoff();
      step(1, 0, 1, 1, 8'h55, 1);
      chk("t5_halt_wins", {PC_Ld, Busy}, 2'b10);
      chk("t5_pc_kept", PC_Addr, 8'hA0);
      step(1, 1, 1, 0, 8'h00, 1);
      chk("t5_start_halt_idle", Busy, 0);
      step(1, 1, 0, 0, 8'h00, 1);
      repeat (W + 1) step(1, 0, 0, 0, 8'h00, 1);
      chk("t5_in_latch", IR_Ld, 0);
      step(1, 0, 1, 0, 8'h00, 1);
      to_handoff();
      step(1, 0, 0, 0, 8'h00, 1);
      chk("t5_pending_idle", Busy, 0);
      step(1, 1, 0, 0, 8'h00, 1);
      repeat (W + 1) step(1, 0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 0, 8'h00, 1);
      chk("t6_reset_busy", Busy, 0);
      chk("t6_reset_count", Fetch_Count, 0);
      chk("t6_reset_memen", MEM_En, 1);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
              1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 2) != 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
